// File: rtl/sw_debounce8_pkg.sv
// Shared constants for the slide-switch debouncer.
// Holds the board and simulation debounce lengths and the counter-width helper.
package sw_debounce8_pkg;

    // Number of raw slide switches on the board.
    localparam int unsigned SW_WIDTH = 8;

    // Consecutive stable clocks needed to accept a new level on the board clock.
    localparam int unsigned DEBOUNCE_CYCLES_BOARD = 20000;

    // Short debounce length so simulations finish in a few hundred cycles.
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

    // Width of the per-bit stability counter. The counter only ever holds
    // values 0..cycles-1, so $clog2(cycles) bits are enough. The result is
    // clamped to at least one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : sw_debounce8_pkg

// File: rtl/sw_debounce8_debounce_bit.sv
// One-bit debouncer: 2-FF synchronizer, stability counter and accepted-level flop.
// flip is combinational. It is high in the cycle whose clock edge will toggle dout.
module debounce_bit
    import sw_debounce8_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic flip
);

    localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    logic             w_differ;
    logic             w_done;

    // The synchronized level disagrees with the accepted level.
    assign w_differ = (r_s2 != r_stable);
    // The disagreement has now lasted DEBOUNCE_CYCLES consecutive compares.
    assign w_done   = w_differ && (r_cnt == CNT_LAST);

    assign flip = w_done;
    assign dout = r_stable;

    // Synchronize the raw level, count how long it disagrees with the accepted
    // level, and accept the new level once the count completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            // NOTE: Use non-blocking assignments here. s1 and s2 must stay
            // two real flops, and the compare must see the old s2 value.
            r_s1 <= din;
            r_s2 <= r_s1;
            if (!w_differ) begin
                // A return to the accepted level cancels any count in progress.
                r_cnt <= '0;
            end else if (w_done) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule : debounce_bit

// File: rtl/sw_debounce8.sv
// Debounces the 8 raw slide switches for the priority-encoder / 7-seg stage.
// Each bit is debounced on its own. The bits are combined into one change
// strobe and a registered "any switch on" flag.
module sw_debounce8
    import sw_debounce8_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_stable,
    output logic             changed,
    output logic             any_on
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_flip;
    logic [WIDTH-1:0] w_stable_next;

    logic             r_changed;
    logic             r_any_on;

    // One independent debouncer per switch bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .din (sw_in[i]),
            .dout(w_stable[i]),
            .flip(w_flip[i])
        );
    end

    // Value sw_stable takes at the coming edge. A flip always toggles its bit.
    assign w_stable_next = w_stable ^ w_flip;

    // Register the combined strobe and the any-on flag on the same edge as the
    // per-bit update, so both line up with the sw_stable value they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_changed <= 1'b0;
            r_any_on  <= 1'b0;
        end else begin
            r_changed <= |w_flip;
            r_any_on  <= |w_stable_next;
        end
    end

    assign sw_stable = w_stable;
    assign changed   = r_changed;
    assign any_on    = r_any_on;

endmodule : sw_debounce8

// File: tb/tb_sw_debounce8.sv
// Self-checking bench for sw_debounce8 with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge.
// A window-based reference model checks every cycle after the first reset.
// Directed scenarios pin exact latencies with literal values.
`timescale 1ns/1ps
module tb_sw_debounce8;
    import sw_debounce8_pkg::*;

    localparam int D    = DEBOUNCE_CYCLES_SIM;
    localparam int W    = 8;
    localparam int MAXE = 4096;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_in = 8'hFF;
    logic [W-1:0] sw_stable;
    logic         changed;
    logic         any_on;

    int checks = 0;
    int errors = 0;

    sw_debounce8 #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_in    (sw_in),
        .sw_stable(sw_stable),
        .changed  (changed),
        .any_on   (any_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Record the input and reset level seen at every rising edge. The level
    // compared at edge n is the input from edge n-2. It is forced to 0 if
    // reset hit edge n-1 or n-2. A bit flips at edge n when the compared
    // level was the same for the last D non-reset edges and differs from
    // the accepted level.
    logic [W-1:0] h_in  [0:MAXE-1];
    bit           h_rst [0:MAXE-1];
    int           n_edge   = 0;
    bit           model_ok = 1'b0;
    logic [W-1:0] m_stable = '0;
    logic         m_changed = 1'b0;
    logic         m_any_on  = 1'b0;

    function automatic logic cmp_val(input int n, input int b);
        if (n < 2) return 1'b0;
        if (h_rst[n-1] || h_rst[n-2]) return 1'b0;
        return h_in[n-2][b];
    endfunction

    always @(posedge clk) begin
        if (n_edge < MAXE) begin
            logic [W-1:0] nxt;
            logic         any_flip;
            h_in[n_edge]  = sw_in;
            h_rst[n_edge] = rst;
            if (rst) begin
                m_stable  = '0;
                m_changed = 1'b0;
                m_any_on  = 1'b0;
                model_ok  = 1'b1;
            end else begin
                nxt      = m_stable;
                any_flip = 1'b0;
                for (int b = 0; b < W; b++) begin
                    bit run_ok;
                    run_ok = 1'b1;
                    for (int k = 0; k < D; k++) begin
                        int idx;
                        idx = n_edge - k;
                        if (idx < 0 || h_rst[idx] || cmp_val(idx, b) == m_stable[b])
                            run_ok = 1'b0;
                    end
                    if (run_ok) begin
                        nxt[b]   = ~m_stable[b];
                        any_flip = 1'b1;
                    end
                end
                m_stable  = nxt;
                m_changed = any_flip;
                m_any_on  = |nxt;
            end
            n_edge++;
            #1;
            if (model_ok) begin
                check("model sw_stable", {24'd0, sw_stable}, {24'd0, m_stable});
                check("model changed", {31'd0, changed}, {31'd0, m_changed});
                check("model any_on", {31'd0, any_on}, {31'd0, m_any_on});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Advance n rising edges and land 1 unit after the last one.
    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset held for two edges with all switches high.
        go(2);
        check("reset sw_stable", {24'd0, sw_stable}, 32'h0);
        check("reset changed", {31'd0, changed}, 32'h0);
        check("reset any_on", {31'd0, any_on}, 32'h0);
        rst   = 1'b0;
        sw_in = 8'h00;
        go(8);
        check("idle sw_stable", {24'd0, sw_stable}, 32'h0);

        // 2. Clean step. The capture edge E is the next edge, and the flip is at E+5.
        sw_in = 8'h80;
        go(5);
        check("step before flip", {24'd0, sw_stable}, 32'h0);
        check("step any_on before", {31'd0, any_on}, 32'h0);
        go(1);
        check("step sw_stable", {24'd0, sw_stable}, 32'h80);
        check("step changed", {31'd0, changed}, 32'h1);
        check("step any_on", {31'd0, any_on}, 32'h1);
        go(1);
        check("step changed drop", {31'd0, changed}, 32'h0);
        sw_in = 8'h00;
        go(8);
        check("step release", {24'd0, sw_stable}, 32'h0);
        check("step release any_on", {31'd0, any_on}, 32'h0);

        // 3. Glitch of D-1 cycles on bit 3.
        sw_in = 8'h08;
        go(3);
        sw_in = 8'h00;
        go(10);
        check("glitch sw_stable", {24'd0, sw_stable}, 32'h0);

        // 4. Bounce on bit 0, then held high.
        sw_in = 8'h01; go(1);
        sw_in = 8'h00; go(1);
        sw_in = 8'h01; go(1);
        sw_in = 8'h00; go(1);
        sw_in = 8'h01;
        go(5);
        check("bounce before flip", {24'd0, sw_stable}, 32'h0);
        go(1);
        check("bounce sw_stable", {24'd0, sw_stable}, 32'h01);
        check("bounce changed", {31'd0, changed}, 32'h1);
        go(1);
        check("bounce changed drop", {31'd0, changed}, 32'h0);
        sw_in = 8'h00;
        go(8);
        check("bounce release", {24'd0, sw_stable}, 32'h0);

        // 5. Two bits rise on the same edge.
        sw_in = 8'h81;
        go(5);
        check("simul before flip", {24'd0, sw_stable}, 32'h0);
        go(1);
        check("simul sw_stable", {24'd0, sw_stable}, 32'h81);
        check("simul changed", {31'd0, changed}, 32'h1);
        go(1);
        check("simul changed drop", {31'd0, changed}, 32'h0);
        sw_in = 8'h00;
        go(8);
        check("simul release", {24'd0, sw_stable}, 32'h0);

        // 6. Reset pulse while the count stands at 2 (edge E+3). Reset hits edge E+4.
        sw_in = 8'h01;
        go(4);
        rst = 1'b1;
        go(1);
        check("midrst sw_stable", {24'd0, sw_stable}, 32'h0);
        check("midrst changed", {31'd0, changed}, 32'h0);
        rst = 1'b0;
        // The first post-reset capture is E+5, so acceptance comes at E+10.
        go(5);
        check("midrst before flip", {24'd0, sw_stable}, 32'h0);
        go(1);
        check("midrst sw_stable after", {24'd0, sw_stable}, 32'h01);
        check("midrst changed pulse", {31'd0, changed}, 32'h1);
        check("midrst any_on", {31'd0, any_on}, 32'h1);
        go(1);
        check("midrst changed drop", {31'd0, changed}, 32'h0);
        go(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sw_debounce8
